// File: rtl/enc_pkg.sv
// Shared constants and FSM state type for the sequential 16-to-4 line encoder.
package enc_pkg;
    localparam int unsigned N_LINES = 16;
    localparam int unsigned IDX_W   = 4;

    typedef enum logic {IDLE, EMIT} state_t;
endpackage

// File: rtl/lowest_set_enc16_4.sv
// Combinational priority encoder: index of the lowest set line, plus an any-set flag.
module lowest_set_enc16_4
    import enc_pkg::*;
(
    input  logic [0:N_LINES-1] lines,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    // Scan from the top down so the lowest set line is written last and wins.
    always_comb begin
        idx = '0;
        for (int i = N_LINES - 1; i >= 0; i--) begin
            if (lines[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

    assign any = |lines;

endmodule

// File: rtl/line_encoder16_4_seq.sv
// Captures a 16-line request vector and emits the index of each active line, lowest first,
// over a valid/ready handshake; done pulses after the last index, zero flags an empty capture.
module line_encoder16_4_seq
    import enc_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [0:N_LINES-1] w,
    input  logic               load,
    input  logic               e,
    output logic [IDX_W-1:0]   y,
    output logic               valid,
    input  logic               ready,
    output logic               busy,
    output logic               done,
    output logic               zero
);

    state_t             state_q, state_d;
    logic [0:N_LINES-1] pending_q, pending_d;
    logic [0:N_LINES-1] remainder;
    logic [0:N_LINES-1] enc_in;
    logic [IDX_W-1:0]   y_q, y_d;
    logic [IDX_W-1:0]   enc_idx;
    logic               enc_any;
    logic               done_q, done_d;
    logic               zero_q, zero_d;

    always_comb begin
        remainder       = pending_q;
        remainder[y_q]  = 1'b0;
    end

    // One encoder serves both phases: the fresh capture in IDLE, the remainder in EMIT.
    assign enc_in = (state_q == IDLE) ? w : remainder;

    lowest_set_enc16_4 u_lowest (
        .lines (enc_in),
        .idx   (enc_idx),
        .any   (enc_any)
    );

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        y_d       = y_q;
        done_d    = 1'b0;
        zero_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (load && e) begin
                    if (enc_any) begin
                        pending_d = w;
                        y_d       = enc_idx;
                        state_d   = EMIT;
                    end else begin
                        zero_d = 1'b1;
                    end
                end
            end
            EMIT: begin
                if (ready) begin
                    pending_d = remainder;
                    if (enc_any) begin
                        y_d = enc_idx;
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pending_q <= '0;
            y_q       <= '0;
            done_q    <= 1'b0;
            zero_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            y_q       <= y_d;
            done_q    <= done_d;
            zero_q    <= zero_d;
        end
    end

    assign y     = y_q;
    assign valid = (state_q == EMIT);
    assign busy  = (state_q == EMIT);
    assign done  = done_q;
    assign zero  = zero_q;

endmodule

// File: tb/tb_line_encoder16_4_seq.sv
// Directed, table-driven bench for line_encoder16_4_seq with hand-computed index sequences.
module tb_line_encoder16_4_seq;

    logic        clk;
    logic        rst_n;
    logic [0:15] w;
    logic        load;
    logic        e;
    logic [3:0]  y;
    logic        valid;
    logic        ready;
    logic        busy;
    logic        done;
    logic        zero;

    int errors = 0;
    int checks = 0;

    line_encoder16_4_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .w     (w),
        .load  (load),
        .e     (e),
        .y     (y),
        .valid (valid),
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .zero  (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // wbits bit i = line i; seq nibble k = k-th expected index.
    typedef struct {
        logic [15:0] wbits;
        int          cnt;
        logic [63:0] seq;
        bit          load_in_emit;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [0:15] to_lines(input logic [15:0] b);
        logic [0:15] r;
        for (int i = 0; i < 16; i++) r[i] = b[i];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_batch(input vec_t v);
        logic [3:0] exp_y;
        w     = to_lines(v.wbits);
        load  = 1'b1;
        e     = 1'b1;
        ready = 1'b1;
        tick();
        load = 1'b0;
        for (int k = 0; k < v.cnt; k++) begin
            exp_y = v.seq[4*k +: 4];
            chk("batch valid", {31'd0, valid}, 32'd1);
            chk("batch busy", {31'd0, busy}, 32'd1);
            chk("batch y", {28'd0, y}, {28'd0, exp_y});
            if (v.load_in_emit && k < v.cnt - 1) begin
                load = 1'b1;
                w    = to_lines(16'h0F0F);
            end else begin
                load = 1'b0;
            end
            tick();
        end
        load = 1'b0;
        chk("batch done", {31'd0, done}, 32'd1);
        chk("batch valid after", {31'd0, valid}, 32'd0);
        chk("batch busy after", {31'd0, busy}, 32'd0);
        chk("batch zero", {31'd0, zero}, 32'd0);
        tick();
        chk("batch done drop", {31'd0, done}, 32'd0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " y"}, {28'd0, y}, 32'd0);
        chk({tag, " valid"}, {31'd0, valid}, 32'd0);
        chk({tag, " busy"}, {31'd0, busy}, 32'd0);
        chk({tag, " done"}, {31'd0, done}, 32'd0);
        chk({tag, " zero"}, {31'd0, zero}, 32'd0);
    endtask

    initial begin
        vecs[0] = '{wbits: 16'h1088, cnt: 3,  seq: 64'h0000_0000_0000_0C73, load_in_emit: 1'b0};
        vecs[1] = '{wbits: 16'hFFFF, cnt: 16, seq: 64'hFEDC_BA98_7654_3210, load_in_emit: 1'b1};
        vecs[2] = '{wbits: 16'h0001, cnt: 1,  seq: 64'h0000_0000_0000_0000, load_in_emit: 1'b0};
        vecs[3] = '{wbits: 16'h8000, cnt: 1,  seq: 64'h0000_0000_0000_000F, load_in_emit: 1'b0};
        vecs[4] = '{wbits: 16'h4002, cnt: 2,  seq: 64'h0000_0000_0000_00E1, load_in_emit: 1'b0};
        vecs[5] = '{wbits: 16'h0020, cnt: 1,  seq: 64'h0000_0000_0000_0005, load_in_emit: 1'b0};

        rst_n = 1'b1;
        w     = '0;
        load  = 1'b0;
        e     = 1'b0;
        ready = 1'b0;
        #1 rst_n = 1'b0;
        #1 chk_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Main table: full-throughput batches, including all-16 with loads during EMIT.
        for (int i = 0; i < 6; i++) run_batch(vecs[i]);

        // Stall on first index: y and valid hold while ready=0.
        w     = to_lines(16'h1088);
        load  = 1'b1;
        e     = 1'b1;
        ready = 1'b0;
        tick();
        load = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("stall valid", {31'd0, valid}, 32'd1);
            chk("stall y", {28'd0, y}, 32'd3);
            tick();
        end
        ready = 1'b1;
        chk("stall y0", {28'd0, y}, 32'd3);
        tick();
        chk("stall y1", {28'd0, y}, 32'd7);
        tick();
        chk("stall y2", {28'd0, y}, 32'd12);
        tick();
        chk("stall done", {31'd0, done}, 32'd1);
        chk("stall valid end", {31'd0, valid}, 32'd0);
        tick();

        // Empty capture: zero pulse, no valid, no busy.
        w    = '0;
        load = 1'b1;
        e    = 1'b1;
        tick();
        load = 1'b0;
        chk("zero pulse", {31'd0, zero}, 32'd1);
        chk("zero valid", {31'd0, valid}, 32'd0);
        chk("zero busy", {31'd0, busy}, 32'd0);
        chk("zero done", {31'd0, done}, 32'd0);
        tick();
        chk("zero drop", {31'd0, zero}, 32'd0);
        chk("zero valid later", {31'd0, valid}, 32'd0);

        // Load with e=0 is ignored.
        w    = to_lines(16'h0010);
        load = 1'b1;
        e    = 1'b0;
        tick();
        load = 1'b0;
        chk("e0 valid", {31'd0, valid}, 32'd0);
        chk("e0 zero", {31'd0, zero}, 32'd0);

        // Reset mid-batch after index 7, then a fresh {5} batch.
        w     = to_lines(16'h1088);
        load  = 1'b1;
        e     = 1'b1;
        ready = 1'b1;
        tick();
        load = 1'b0;
        chk("mid y3", {28'd0, y}, 32'd3);
        tick();
        chk("mid y7", {28'd0, y}, 32'd7);
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        w     = to_lines(16'h0020);
        load  = 1'b1;
        tick();
        load = 1'b0;
        chk("after rst y5", {28'd0, y}, 32'd5);
        chk("after rst valid", {31'd0, valid}, 32'd1);
        tick();
        chk("after rst done", {31'd0, done}, 32'd1);
        // A load is accepted in the same cycle done is high.
        w    = to_lines(16'h0004);
        load = 1'b1;
        tick();
        load = 1'b0;
        chk("done-cycle load y", {28'd0, y}, 32'd2);
        chk("done-cycle load valid", {31'd0, valid}, 32'd1);
        chk("done-cycle done drop", {31'd0, done}, 32'd0);
        tick();
        chk("done-cycle batch done", {31'd0, done}, 32'd1);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
